// File: rtl/matmul_pkg.sv
// Shared opcode/state definitions for the systolic matmul sequencer and the decode stage.
package matmul_pkg;

  typedef enum logic [2:0] {
    OP_NONE     = 3'b000,
    OP_WRITE_A  = 3'b001,
    OP_WRITE_B  = 3'b010,
    OP_WRITE_C  = 3'b011,
    OP_MATMUL   = 3'b100,
    OP_READ_C   = 3'b101,
    OP_STEP     = 3'b110,
    OP_NONE_ALT = 3'b111
  } matmul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_READ = 2'd2
  } seq_state_e;

  // A full DIM x DIM product needs the operand wavefront to cross the array diagonally.
  function automatic int matmul_steps(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// Turns decoded matmul-class commands into single-cycle strobes for the systolic array,
// runs matmul step bursts and waits for readC data, stalling issue while busy.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DIM        = 4,
  parameter int IDX_W      = $clog2(DIM),
  parameter int RD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic             cmd_high_low,
  output logic             sa_write_a,
  output logic             sa_write_b,
  output logic             sa_write_c,
  output logic [IDX_W-1:0] sa_row,
  output logic             sa_step,
  output logic             sa_read_c,
  output logic             sa_high_low,
  input  logic             sa_rd_valid,
  output logic             vwb_en,
  output logic             busy,
  output logic             stall,
  output logic             err
);

  localparam int STEPS = matmul_steps(DIM);
  localparam int CNT_W = $clog2(3 * DIM);
  localparam int RD_W  = $clog2(RD_TIMEOUT + 1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_step_cnt;
  logic [RD_W-1:0]  r_rd_cnt;
  logic [DIM-1:0]   r_a_mask;
  logic [DIM-1:0]   r_b_mask;
  logic             r_write_a;
  logic             r_write_b;
  logic             r_write_c;
  logic             r_step;
  logic             r_read_c;
  logic             r_high_low;
  logic [IDX_W-1:0] r_row;
  logic             r_err;

  logic             w_accept;
  matmul_op_e       w_op;
  logic             w_masks_full;
  logic [DIM-1:0]   w_a_mask_next;
  logic [DIM-1:0]   w_b_mask_next;

  assign cmd_ready    = (r_state == ST_IDLE);
  assign w_accept     = cmd_valid & cmd_ready;
  assign w_op         = matmul_op_e'(cmd_opcode);
  assign w_masks_full = (&r_a_mask) & (&r_b_mask);

  // Row-loaded tracking: setting an already-set bit is harmless, so no read-modify check.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_mask
      assign w_a_mask_next[gi] = r_a_mask[gi] |
        (w_accept & (w_op == OP_WRITE_A) & (cmd_idx == IDX_W'(gi)));
      assign w_b_mask_next[gi] = r_b_mask[gi] |
        (w_accept & (w_op == OP_WRITE_B) & (cmd_idx == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_step_cnt <= '0;
      r_rd_cnt   <= '0;
      r_a_mask   <= '0;
      r_b_mask   <= '0;
      r_write_a  <= 1'b0;
      r_write_b  <= 1'b0;
      r_write_c  <= 1'b0;
      r_step     <= 1'b0;
      r_read_c   <= 1'b0;
      r_high_low <= 1'b0;
      r_row      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_write_a <= 1'b0;
      r_write_b <= 1'b0;
      r_write_c <= 1'b0;
      r_step    <= 1'b0;
      r_read_c  <= 1'b0;
      r_err     <= 1'b0;
      r_a_mask  <= w_a_mask_next;
      r_b_mask  <= w_b_mask_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_WRITE_A: begin
                r_write_a <= 1'b1;
                r_row     <= cmd_idx;
              end
              OP_WRITE_B: begin
                r_write_b <= 1'b1;
                r_row     <= cmd_idx;
              end
              OP_WRITE_C: begin
                r_write_c <= 1'b1;
                r_row     <= cmd_idx;
              end
              OP_STEP: r_step <= 1'b1;
              OP_MATMUL: begin
                if (w_masks_full) begin
                  r_state    <= ST_RUN;
                  r_step     <= 1'b1;
                  r_step_cnt <= CNT_W'(STEPS - 1);
                end else begin
                  r_err <= 1'b1;
                end
              end
              OP_READ_C: begin
                r_read_c   <= 1'b1;
                r_row      <= cmd_idx;
                r_high_low <= cmd_high_low;
                r_rd_cnt   <= '0;
                r_state    <= ST_READ;
              end
              default: ;
            endcase
          end
        end
        // r_step_cnt holds the number of step cycles still to come after the current one.
        ST_RUN: begin
          if (r_step_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_step     <= 1'b1;
            r_step_cnt <= r_step_cnt - CNT_W'(1);
          end
        end
        ST_READ: begin
          if (sa_rd_valid) begin
            r_state <= ST_IDLE;
          end else if (r_rd_cnt == RD_W'(RD_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_rd_cnt <= r_rd_cnt + RD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sa_write_a  = r_write_a;
  assign sa_write_b  = r_write_b;
  assign sa_write_c  = r_write_c;
  assign sa_step     = r_step;
  assign sa_read_c   = r_read_c;
  assign sa_high_low = r_high_low;
  assign sa_row      = r_row;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);
  assign stall       = cmd_valid & ~cmd_ready;
  assign vwb_en      = (r_state == ST_READ) & sa_rd_valid;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: command table plus directed burst/read/reset sequences,
// with a strobe scoreboard fed at issue time and drained by a negedge monitor.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DIM        = 4;
  localparam int IDX_W      = 2;
  localparam int RD_TIMEOUT = 16;
  localparam int STEPS      = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode = 3'b000;
  logic [IDX_W-1:0] cmd_idx = '0;
  logic             cmd_high_low = 1'b0;
  logic             sa_write_a, sa_write_b, sa_write_c;
  logic [IDX_W-1:0] sa_row;
  logic             sa_step, sa_read_c, sa_high_low;
  logic             sa_rd_valid = 1'b0;
  logic             vwb_en, busy, stall, err;

  always #5 clk = ~clk;

  matmul_sequencer #(.DIM(DIM), .IDX_W(IDX_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_idx(cmd_idx), .cmd_high_low(cmd_high_low),
    .sa_write_a(sa_write_a), .sa_write_b(sa_write_b), .sa_write_c(sa_write_c),
    .sa_row(sa_row), .sa_step(sa_step), .sa_read_c(sa_read_c), .sa_high_low(sa_high_low),
    .sa_rd_valid(sa_rd_valid), .vwb_en(vwb_en), .busy(busy), .stall(stall), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0, vwb_cnt = 0, step_cnt = 0, busy_cnt = 0;

  // kind: 1 writeA, 2 writeB, 3 writeC, 4 step, 5 readC
  typedef struct { int kind; int row; logic hl; } sb_t;
  sb_t sb_q[$];

  typedef struct { logic [2:0] op; int idx; logic hl; int exp_kind; } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int row, input logic hl);
    sb_t e;
    e.kind = kind;
    e.row  = row;
    e.hl   = hl;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input int idx, input logic hl);
    cmd_valid    = 1'b1;
    cmd_opcode   = op;
    cmd_idx      = IDX_W'(idx);
    cmd_high_low = hl;
  endtask

  always @(negedge clk) begin : monitor
    int n;
    int kind;
    sb_t e;
    n = int'(sa_write_a) + int'(sa_write_b) + int'(sa_write_c) + int'(sa_step) + int'(sa_read_c);
    check("strobe_onehot", int'(n <= 1), 1);
    kind = sa_write_a ? 1 : sa_write_b ? 2 : sa_write_c ? 3 : sa_step ? 4 : sa_read_c ? 5 : 0;
    if (n == 1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", kind, 0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", kind, e.kind);
        if (kind != 4) check("strobe_row", int'(sa_row), e.row);
        if (kind == 5) check("strobe_hl", int'(sa_high_low), int'(e.hl));
      end
    end
    if (err)     err_cnt++;
    if (vwb_en)  vwb_cnt++;
    if (sa_step) step_cnt++;
    if (busy)    busy_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, s0, v0, b0;

    // Reset state
    #1;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_err", int'(err), 0);
    check("rst_step", int'(sa_step), 0);
    check("rst_vwb", int'(vwb_en), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back single-cycle commands
    for (int i = 0; i < 4; i++) vecs[i]     = '{3'b001, i, 1'b0, 1};
    for (int i = 0; i < 4; i++) vecs[4 + i] = '{3'b010, i, 1'b0, 2};
    vecs[8]  = '{3'b011, 3, 1'b0, 3};
    vecs[9]  = '{3'b110, 0, 1'b0, 4};
    vecs[10] = '{3'b000, 1, 1'b0, 0};
    vecs[11] = '{3'b111, 2, 1'b1, 0};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].idx, vecs[i].hl);
      #1;
      check("tbl_ready", int'(cmd_ready), 1);
      if (vecs[i].exp_kind != 0) push(vecs[i].exp_kind, vecs[i].idx, 1'b0);
      $display("cmd %0d: op=%0d idx=%0d expect_strobe_kind=%0d", i, vecs[i].op, vecs[i].idx,
               vecs[i].exp_kind);
      tick();
    end
    cmd_valid = 1'b0;
    tick(); tick();
    check("tbl_sb_drained", sb_q.size(), 0);

    // Two matmul bursts, second held on cmd_valid while the first runs
    s0 = step_cnt;
    drive(3'b100, 0, 1'b0);
    for (int k = 0; k < STEPS; k++) push(4, 0, 1'b0);
    tick();
    for (int k = 1; k <= STEPS; k++) begin
      check("mm1_step", int'(sa_step), 1);
      check("mm1_ready", int'(cmd_ready), 0);
      check("mm1_stall", int'(stall), 1);
      check("mm1_busy", int'(busy), 1);
      tick();
    end
    check("mm1_ready_back", int'(cmd_ready), 1);
    check("mm1_step_off", int'(sa_step), 0);
    for (int k = 0; k < STEPS; k++) push(4, 0, 1'b0);
    $display("matmul burst 1 done, reissuing held matmul");
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= STEPS; k++) begin
      check("mm2_step", int'(sa_step), 1);
      tick();
    end
    check("mm2_ready_back", int'(cmd_ready), 1);
    check("mm2_step_off", int'(sa_step), 0);
    tick();
    check("mm_step_total", step_cnt - s0, 2 * STEPS);
    $display("matmul burst 2 done");

    // readC with data returning three cycles after the strobe
    v0 = vwb_cnt;
    drive(3'b101, 2, 1'b1);
    push(5, 2, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("rc_busy", int'(busy), 1);
    check("rc_vwb_early", int'(vwb_en), 0);
    tick(); tick(); tick();
    sa_rd_valid = 1'b1;
    #1;
    check("rc_vwb", int'(vwb_en), 1);
    tick();
    sa_rd_valid = 1'b0;
    #1;
    check("rc_ready", int'(cmd_ready), 1);
    check("rc_vwb_after", int'(vwb_en), 0);
    tick();
    check("rc_vwb_count", vwb_cnt - v0, 1);
    $display("readC idx=2 hl=1 complete");

    // readC with data in the strobe cycle, then data outside READ
    drive(3'b101, 0, 1'b0);
    push(5, 0, 1'b0);
    tick();
    cmd_valid   = 1'b0;
    sa_rd_valid = 1'b1;
    #1;
    check("rc0_vwb_strobe_cycle", int'(vwb_en), 1);
    tick();
    check("rc0_ready", int'(cmd_ready), 1);
    check("idle_vwb_ignored", int'(vwb_en), 0);
    tick();
    check("idle_busy", int'(busy), 0);
    sa_rd_valid = 1'b0;
    tick();
    $display("readC idx=0 immediate data complete");

    // readC timeout
    e0 = err_cnt;
    v0 = vwb_cnt;
    drive(3'b101, 1, 1'b0);
    push(5, 1, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= RD_TIMEOUT; c++) begin
      check("to_err_early", int'(err), 0);
      check("to_busy", int'(busy), 1);
      tick();
    end
    check("to_err", int'(err), 1);
    check("to_ready", int'(cmd_ready), 1);
    tick();
    check("to_err_pulse", int'(err), 0);
    check("to_err_count", err_cnt - e0, 1);
    check("to_vwb_count", vwb_cnt - v0, 0);
    $display("readC idx=1 timeout complete");

    // Reset during step 5 of a burst
    drive(3'b100, 0, 1'b0);
    for (int k = 0; k < STEPS; k++) push(4, 0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("rstmid_step5", int'(sa_step), 1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rstmid_step_off", int'(sa_step), 0);
    check("rstmid_ready", int'(cmd_ready), 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rstmid_ready_rel", int'(cmd_ready), 1);
    check("rstmid_no_step", int'(sa_step), 0);
    $display("reset mid-burst complete");

    // Only A loaded: matmul must flag err and not run
    for (int i = 0; i < DIM; i++) begin
      drive(3'b001, i, 1'b0);
      push(1, i, 1'b0);
      tick();
    end
    e0 = err_cnt;
    s0 = step_cnt;
    b0 = busy_cnt;
    drive(3'b100, 0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("inc_err", int'(err), 1);
    check("inc_step", int'(sa_step), 0);
    check("inc_busy", int'(busy), 0);
    tick();
    check("inc_err_pulse", int'(err), 0);
    for (int k = 0; k < 12; k++) tick();
    check("inc_err_count", err_cnt - e0, 1);
    check("inc_step_count", step_cnt - s0, 0);
    check("inc_busy_count", busy_cnt - b0, 0);
    check("final_sb_drained", sb_q.size(), 0);
    $display("incomplete-mask matmul complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
